// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response channel between the fetch sequencer and imem.
// Master issues req/addr and holds them until the slave raises ready with rdata valid.
interface fetch_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic [DATA_W-1:0] addr;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input  ready, input  rdata);
    modport slave  (input  req, input  addr, output ready, output rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, runs the imem req/ready handshake and keeps
// one fetched instruction in a single-entry buffer, honouring stall, branch and flush redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              flush,
    input  logic [DATA_W-1:0] flush_target,
    fetch_ctrl_if.master      imem,
    output logic              ce,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] inst_pc
);
    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] pc;
    logic              redir_pending;
    logic [DATA_W-1:0] redir_pc;

    logic              consume;
    logic              space;
    logic              redirect;
    logic [DATA_W-1:0] redir_tgt;
    logic              complete;
    logic              discard;

    assign consume   = inst_valid & ~stall;
    assign space     = ~inst_valid | ~stall;
    assign redirect  = flush | branch_flag;
    assign redir_tgt = flush ? flush_target : branch_target;
    assign complete  = imem.req & imem.ready;
    // A response landing with a redirect this cycle or one queued during WAIT is stale.
    assign discard   = complete & (redirect | redir_pending);

    assign imem.addr = pc;

    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    always_comb begin
        imem.req = 1'b0;
        if (!rst) begin
            case (state)
                ST_ISSUE: imem.req = space & ~redirect;
                ST_WAIT:  imem.req = 1'b1;
                default:  imem.req = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RST;
            ce            <= 1'b0;
            pc            <= DATA_W'(RESET_PC);
            redir_pending <= 1'b0;
            redir_pc      <= '0;
            inst_valid    <= 1'b0;
            inst          <= '0;
            inst_pc       <= '0;
        end else begin
            ce <= 1'b1;

            case (state)
                ST_RST:   state <= ST_ISSUE;
                ST_ISSUE: if (imem.req && !imem.ready) state <= ST_WAIT;
                ST_WAIT:  if (imem.ready) state <= ST_ISSUE;
                default:  state <= ST_RST;
            endcase

            if (complete) begin
                redir_pending <= 1'b0;
                if (discard) pc <= redirect ? redir_tgt : redir_pc;
                else         pc <= pc + DATA_W'(4);
            end else if (redirect) begin
                if (state == ST_WAIT) begin
                    redir_pending <= 1'b1;
                    redir_pc      <= redir_tgt;
                end else if (state == ST_ISSUE) begin
                    pc <= redir_tgt;
                end
            end

            // Completion only happens with the buffer empty or draining, so no live entry is lost.
            if (complete && !discard) begin
                inst_valid <= 1'b1;
                inst       <= imem.rdata;
                inst_pc    <= pc;
            end else if (redirect || discard || consume) begin
                inst_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequential fetch, wait states, stall, redirects,
// PC wrap and reset during an outstanding request.
module tb_fetch_ctrl;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_target;
    logic        ce;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        use_ovr;
    logic [31:0] ovr_data;

    int checks = 0;
    int errors = 0;

    fetch_ctrl_if #(.DATA_W(32)) bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .flush_target  (flush_target),
        .imem          (bus.master),
        .ce            (ce),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign bus.rdata = use_ovr ? ovr_data : inst_of(bus.addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = '0;
        flush = 1'b0; flush_target = '0; bus.ready = 1'b1; use_ovr = 1'b0; ovr_data = '0;

        repeat (3) tick();
        check("rst_ce",      32'(ce),         32'd0);
        check("rst_valid",   32'(inst_valid), 32'd0);
        check("rst_inst",    inst,            32'd0);
        check("rst_inst_pc", inst_pc,         32'd0);
        check("rst_req",     32'(bus.req),    32'd0);
        check("rst_addr",    bus.addr,        32'd0);

        rst = 1'b0; #1;
        check("rel_req", 32'(bus.req), 32'd0);
        check("rel_ce",  32'(ce),      32'd0);

        tick();
        check("first_ce",    32'(ce),         32'd1);
        check("first_req",   32'(bus.req),    32'd1);
        check("first_addr",  bus.addr,        32'd0);
        check("first_valid", 32'(inst_valid), 32'd0);

        for (int i = 0; i < 2; i++) begin
            tick();
            check("seq_valid", 32'(inst_valid), 32'd1);
            check("seq_pc",    inst_pc,         32'(i * 4));
            check("seq_inst",  inst,            inst_of(32'(i * 4)));
            check("seq_addr",  bus.addr,        32'(i * 4 + 4));
        end

        bus.ready = 1'b0;
        repeat (3) begin
            tick();
            check("wait_req",   32'(bus.req),    32'd1);
            check("wait_addr",  bus.addr,        32'd8);
            check("wait_valid", 32'(inst_valid), 32'd0);
        end
        use_ovr = 1'b1; ovr_data = 32'hDEAD_BEEF; bus.ready = 1'b1;
        tick();
        use_ovr = 1'b0;
        check("ws_inst",  inst,            32'hDEAD_BEEF);
        check("ws_pc",    inst_pc,         32'd8);
        check("ws_valid", 32'(inst_valid), 32'd1);
        check("ws_addr",  bus.addr,        32'd12);

        stall = 1'b1; #1;
        check("stall_req0", 32'(bus.req), 32'd0);
        repeat (4) begin
            tick();
            check("stall_inst",  inst,            32'hDEAD_BEEF);
            check("stall_pc",    inst_pc,         32'd8);
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_req",   32'(bus.req),    32'd0);
            check("stall_addr",  bus.addr,        32'd12);
        end
        stall = 1'b0; #1;
        check("unstall_req",  32'(bus.req), 32'd1);
        check("unstall_addr", bus.addr,     32'd12);
        tick();
        check("unstall_pc",   inst_pc,  32'd12);
        check("unstall_inst", inst,     inst_of(32'd12));
        check("unstall_next", bus.addr, 32'd16);

        for (int j = 0; j < 4; j++) begin
            tick();
            check("run_pc", inst_pc, 32'(16 + 4 * j));
        end
        check("run_addr", bus.addr, 32'h20);

        bus.ready = 1'b0;
        tick();
        check("bw_addr",  bus.addr,        32'h20);
        check("bw_valid", 32'(inst_valid), 32'd0);
        branch_flag = 1'b1; branch_target = 32'h100; #1;
        check("bw_req", 32'(bus.req), 32'd1);
        tick();
        branch_flag = 1'b0;
        check("bw_hold1", bus.addr, 32'h20);
        tick();
        check("bw_hold2", bus.addr, 32'h20);
        bus.ready = 1'b1;
        tick();
        check("bw_discard", 32'(inst_valid), 32'd0);
        check("bw_target",  bus.addr,        32'h100);
        check("bw_req2",    32'(bus.req),    32'd1);
        tick();
        check("bt_valid", 32'(inst_valid), 32'd1);
        check("bt_pc",    inst_pc,         32'h100);
        check("bt_addr",  bus.addr,        32'h104);

        flush = 1'b1; flush_target = 32'h180; branch_flag = 1'b1; branch_target = 32'h100; #1;
        check("fl_req", 32'(bus.req), 32'd0);
        tick();
        flush = 1'b0; branch_flag = 1'b0;
        check("fl_valid", 32'(inst_valid), 32'd0);
        check("fl_addr",  bus.addr,        32'h180);
        #1;
        check("fl_req2", 32'(bus.req), 32'd1);

        branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_flag = 1'b0;
        check("wr_addr",  bus.addr,        32'hFFFF_FFFC);
        check("wr_valid", 32'(inst_valid), 32'd0);
        tick();
        check("wr_pc",   inst_pc,  32'hFFFF_FFFC);
        check("wr_next", bus.addr, 32'd0);
        tick();
        check("wr_pc0",   inst_pc,  32'd0);
        check("wr_addr4", bus.addr, 32'd4);

        bus.ready = 1'b0;
        tick();
        check("rw_req",  32'(bus.req), 32'd1);
        check("rw_addr", bus.addr,     32'd4);
        rst = 1'b1; #1;
        check("rw_req_rst", 32'(bus.req), 32'd0);
        tick();
        check("rw_ce",    32'(ce),         32'd0);
        check("rw_pc",    bus.addr,        32'd0);
        check("rw_valid", 32'(inst_valid), 32'd0);
        check("rw_req0",  32'(bus.req),    32'd0);
        rst = 1'b0; bus.ready = 1'b1;
        tick();
        check("rw_ce1",   32'(ce),      32'd1);
        check("rw_addr0", bus.addr,     32'd0);
        check("rw_req1",  32'(bus.req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
